sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
Initiator side of the stored-image ROM lookup. On a START request it scans all 32x32 sprite coordinates of one IMG_ID. It drives CLM/ROW/IMG_ID into the combinational stored-image decoder and samples COLOR, then writes opaque, on-screen pixels into the 4-bit framebuffer through a ready/write handshake. It sits in the graphic processing unit between the command path and the framebuffer write port.

Parameters:
SCREEN_W, 640, framebuffer width in pixels
SCREEN_H, 480, framebuffer height in pixels
ADDR_W, 19, framebuffer address width (fits SCREEN_W*SCREEN_H)
TRANSPARENT, 4'b0000, COLOR value never written

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-high
START  in  1  draw request, sampled only in IDLE
IMG_ID_IN  in  10  sprite id to draw
POS_X  in  10  screen x of sprite top-left
POS_Y  in  10  screen y of sprite top-left
CLM  out  5  decoder first index = vertical offset (sprite line)
ROW  out  5  decoder second index = horizontal offset
IMG_ID  out  10  latched sprite id to decoder
COLOR  in  4  decoder pixel, combinational from CLM/ROW/IMG_ID
FB_WE  out  1  framebuffer write valid
FB_ADDR  out  ADDR_W  framebuffer pixel address
FB_DATA  out  4  pixel colour
FB_READY  in  1  framebuffer accepts write when FB_WE&&FB_READY
BUSY  out  1  draw in progress
DONE  out  1  one-cycle pulse, draw complete

Behaviour:
- Clocking: one clock CLK; RST synchronous, active-high. Reset: state IDLE, CLM=ROW=0, IMG_ID=0, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, DONE=0, stage-1 valid=0.
- FSM: IDLE, SCAN, DRAIN, FINISH.
- IDLE: START=1 at edge k latches IMG_ID_IN/POS_X/POS_Y, clears counters, sets line base = POS_Y*SCREEN_W, goes to SCAN. BUSY=1 from cycle k+1. START in any other state is ignored.
- SCAN, stage 0: CLM/ROW come from the counters. COLOR is valid in the same cycle.
  - Target x = POS_X+ROW and y = POS_Y+CLM, each 11 bits with no wrap.
  - Stage 1 captures COLOR, address = line base + x, and a write flag = (COLOR!=TRANSPARENT) && x<SCREEN_W && y<SCREEN_H.
- Line base update: incremental add of SCREEN_W per CLM increment. No multiplier in the scan loop.
- Scan order: ROW fastest 0..31, then CLM 0..31. After capture of (CLM=31,ROW=31), go to DRAIN. Counters stop and do not wrap.
- Stage 1 output: FB_WE = stage-1 valid && write flag.
  - A beat retires when FB_WE=0 (skipped pixel needs no FB_READY) or FB_WE&&FB_READY.
  - While FB_WE=1 and FB_READY=0: stage 0 and stage 1 freeze, and CLM/ROW/FB_ADDR/FB_DATA hold stable.
- DRAIN: wait for the last beat to retire, then go to FINISH.
- FINISH: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
- Latency with FB_READY=1: scan cycles k+1..k+1024, stage-1 beats k+2..k+1025, DONE at k+1026. Each stall cycle adds one cycle.
- RST mid-draw: the pending write is dropped and all outputs return to reset values on the next cycle. No partial DONE.
- POS outside the screen: every pixel is clipped. All 1024 beats still retire with FB_WE=0, and DONE timing is unchanged.

Decomposition:
- Shared package gpu_pkg holds: SPRITE_DIM=32, TRANSPARENT_COLOR, SCREEN_W/SCREEN_H defaults, blitter state enum.
- One sub-module is natural: sprite_addr_gen, holding the ROW/CLM counters, line-base accumulator, target x/y and clip flags.
- Handshake, stage 1 and FSM stay in sprite_blitter. The decoder is instantiated by the parent, not inside.

Test Plan:
- Reset: hold RST 2 cycles with START=1 -> all outputs 0, BUSY stays 0, no FB_WE.
- Full draw, FB_READY=1, POS=(100,50), model COLOR=4'b0100 for all pixels:
  - 1024 writes.
  - First FB_ADDR=32100 at k+2; last FB_ADDR=51971 at k+1025.
  - DONE only at k+1026.
- Transparency: model COLOR=0 when ROW even, else 4'b0101 -> 512 writes, all FB_DATA=5, DONE still at k+1026.
- Clipping: POS=(620,470), opaque model -> exactly 200 writes (ROW<20, CLM<10); no FB_ADDR >= 307200.
- Stall: FB_READY=0 for 3 cycles at the 10th write -> FB_ADDR/FB_DATA/CLM/ROW held stable, no lost or duplicated pixel, DONE at k+1029.
- Busy and reset:
  - START pulsed mid-draw -> ignored, IMG_ID unchanged.
  - RST at scan cycle 500 -> FB_WE=0 and BUSY=0 next cycle, no DONE.
  - A new START after reset draws the full 1024 beats.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: sprite geometry, screen defaults and the blitter state encoding.
package gpu_pkg;
  localparam int SPRITE_DIM = 32;
  localparam int SPRITE_BITS = 5;
  localparam logic [3:0] TRANSPARENT_COLOR = 4'b0000;
  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;
  localparam int ADDR_W_DEFAULT = 19;

  typedef enum logic [1:0] {
    BLIT_IDLE,
    BLIT_SCAN,
    BLIT_DRAIN,
    BLIT_FINISH
  } blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Framebuffer write port. A beat transfers on a cycle where FB_WE && FB_READY;
// once FB_WE is raised, FB_ADDR/FB_DATA hold stable until FB_READY accepts the beat.
interface sprite_blitter_if #(
  parameter int ADDR_W = 19
) ();
  logic              FB_WE;
  logic [ADDR_W-1:0] FB_ADDR;
  logic [3:0]        FB_DATA;
  logic              FB_READY;

  modport master (output FB_WE, output FB_ADDR, output FB_DATA, input FB_READY);
  modport slave  (input FB_WE, input FB_ADDR, input FB_DATA, output FB_READY);
endinterface

// File: rtl/sprite_addr_gen.sv
// Sprite scan counters (ROW fastest, then CLM), incremental line base and on-screen test
// for the pixel currently presented to the image decoder.
module sprite_addr_gen
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [9:0]             pos_x,
  input  logic [9:0]             pos_y,
  output logic [SPRITE_BITS-1:0] clm,
  output logic [SPRITE_BITS-1:0] row,
  output logic [ADDR_W-1:0]      addr,
  output logic                   on_screen,
  output logic                   last
);
  localparam logic [SPRITE_BITS-1:0] MAX_IDX = SPRITE_BITS'(SPRITE_DIM - 1);

  logic [9:0]        base_x;
  logic [9:0]        base_y;
  logic [ADDR_W-1:0] line_base;
  logic [10:0]       tgt_x;
  logic [10:0]       tgt_y;

  // 11-bit sums so a sprite hanging past the right/bottom edge never wraps back on screen.
  assign tgt_x     = {1'b0, base_x} + {6'd0, row};
  assign tgt_y     = {1'b0, base_y} + {6'd0, clm};
  assign on_screen = (tgt_x < 11'(SCREEN_W)) && (tgt_y < 11'(SCREEN_H));
  assign addr      = line_base + ADDR_W'(tgt_x);
  assign last      = (clm == MAX_IDX) && (row == MAX_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      base_x    <= '0;
      base_y    <= '0;
      line_base <= '0;
      clm       <= '0;
      row       <= '0;
    end else if (load) begin
      base_x    <= pos_x;
      base_y    <= pos_y;
      clm       <= '0;
      row       <= '0;
      // The only multiply happens once per draw; the scan loop just adds SCREEN_W per line.
      line_base <= ADDR_W'(pos_y) * ADDR_W'(SCREEN_W);
    end else if (step && !last) begin
      row <= row + 1'b1;
      if (row == MAX_IDX) begin
        clm       <= clm + 1'b1;
        line_base <= line_base + ADDR_W'(SCREEN_W);
      end
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans one 32x32 sprite through the image decoder and streams opaque,
// on-screen pixels into the framebuffer through a two-stage (present / write) pipeline.
module sprite_blitter
  import gpu_pkg::*;
#(
  parameter int         SCREEN_W    = SCREEN_W_DEFAULT,
  parameter int         SCREEN_H    = SCREEN_H_DEFAULT,
  parameter int         ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [3:0] TRANSPARENT = TRANSPARENT_COLOR
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [9:0]             IMG_ID_IN,
  input  logic [9:0]             POS_X,
  input  logic [9:0]             POS_Y,
  output logic [SPRITE_BITS-1:0] CLM,
  output logic [SPRITE_BITS-1:0] ROW,
  output logic [9:0]             IMG_ID,
  input  logic [3:0]             COLOR,
  sprite_blitter_if.master       fb,
  output logic                   BUSY,
  output logic                   DONE
);
  blit_state_t       state;
  logic              s1_valid;
  logic              wr_flag;
  logic [ADDR_W-1:0] s1_addr;
  logic [3:0]        s1_data;
  logic [9:0]        img_id;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] gen_addr;
  logic              on_screen;
  logic              last;
  logic              advance;
  logic              load;
  logic              step;

  // A beat retires unless a real write is waiting on FB_READY; skipped pixels never wait.
  assign advance = !(fb.FB_WE && !fb.FB_READY);
  assign load    = (state == BLIT_IDLE) && START;
  assign step    = (state == BLIT_SCAN) && advance;

  sprite_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .step      (step),
    .pos_x     (POS_X),
    .pos_y     (POS_Y),
    .clm       (CLM),
    .row       (ROW),
    .addr      (gen_addr),
    .on_screen (on_screen),
    .last      (last)
  );

  assign fb.FB_WE   = s1_valid && wr_flag;
  assign fb.FB_ADDR = s1_addr;
  assign fb.FB_DATA = s1_data;
  assign IMG_ID     = img_id;
  assign BUSY       = busy;
  assign DONE       = done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= BLIT_IDLE;
      s1_valid <= 1'b0;
      wr_flag  <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      img_id   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        BLIT_IDLE: begin
          done <= 1'b0;
          if (START) begin
            img_id <= IMG_ID_IN;
            busy   <= 1'b1;
            state  <= BLIT_SCAN;
          end
        end
        BLIT_SCAN: begin
          if (advance) begin
            s1_valid <= 1'b1;
            s1_addr  <= gen_addr;
            s1_data  <= COLOR;
            wr_flag  <= (COLOR != TRANSPARENT) && on_screen;
            if (last) state <= BLIT_DRAIN;
          end
        end
        BLIT_DRAIN: begin
          if (advance) begin
            s1_valid <= 1'b0;
            wr_flag  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= BLIT_FINISH;
          end
        end
        BLIT_FINISH: begin
          done  <= 1'b0;
          state <= BLIT_IDLE;
        end
        default: state <= BLIT_IDLE;
      endcase
    end
  end
endmodule
